pe_res_collector: RTL and testbench
===================================

Name: pe_res_collector

Overview:
- Receiving end of the PE result-write interface (wr_en / wr_adr / result byte).
- Captures one PE's convolution output map into an internal result buffer.
- After the PE signals done, streams the map out in raster order over a valid/ready handshake, as the input image of the next layer.
- One instance per PE.

Parameters:
- IMG_SIZE, 16, input image side length.
- FILTER_SIZE, 4, filter side length.
- RES_SIZE, (IMG_SIZE-FILTER_SIZE+1)^2 = 169, number of result entries. Must be ≤ 256 because the address is 8 bits.
- CNT_W, $clog2(RES_SIZE+1) = 8, width of the write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms the collector.
- z  in  8  zero-point value; substituted for entries that were never written.
- wr_en  in  1  PE result-write strobe.
- wr_adr  in  8  PE result address.
- wr_data  in  8  PE result byte.
- pe_done  in  1  one-cycle pulse from the PE when its map is complete.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  stream byte.
- out_last  out  1  high with the final byte (index RES_SIZE-1).
- wr_cnt  out  CNT_W  number of distinct addresses written.
- full  out  1  wr_cnt == RES_SIZE.
- err  out  1  sticky; an out-of-range write was seen.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the stream completes.

Behaviour:
- Storage: mem[0:RES_SIZE-1] × 8 bits, plus a written bitmap wb[0:RES_SIZE-1].
- Reset (rst=1 at a clock edge, at any point including mid-stream):
  - state=IDLE; rd_ptr=0; wb all 0; wr_cnt=0; err=0.
  - out_valid=0, out_last=0, done=0, busy=0.
  - out_data=0 while out_valid=0.
  - mem contents are don't-care.
- FSM states: IDLE, COLLECT, DRAIN, FIN.
- IDLE:
  - start=1 → COLLECT next cycle. Same edge: clear wb, wr_cnt, err, rd_ptr.
  - wr_en and pe_done are ignored in IDLE.
- COLLECT:
  - wr_en=1 and wr_adr<RES_SIZE: mem[wr_adr]←wr_data. If wb[wr_adr]=0, set it and increment wr_cnt.
  - A rewrite of an address overwrites the data; wr_cnt is unchanged.
  - wr_en=1 and wr_adr≥RES_SIZE: no write; err←1.
  - pe_done=1 → DRAIN next cycle. A wr_en in the same cycle as pe_done is still captured.
  - start is ignored in any state other than IDLE.
- DRAIN:
  - out_valid=1 (combinational from state).
  - out_data = wb[rd_ptr] ? mem[rd_ptr] : z.
  - out_last = (rd_ptr == RES_SIZE-1).
  - out_valid&&out_ready: rd_ptr++. If out_last, go to FIN instead.
  - out_ready=0: out_data and out_last hold stable; out_valid stays 1.
  - wr_en is ignored in DRAIN (no write, no err).
- FIN: done=1 for exactly one cycle, then IDLE. wr_cnt, full and err hold until the next start or reset.
- Latency: first byte is valid 1 cycle after pe_done. With out_ready held high, RES_SIZE bytes follow on consecutive cycles; done is asserted on the cycle after the last byte's handshake.
- Arithmetic: wr_cnt never exceeds RES_SIZE. full is combinational from wr_cnt.
- pe_done with zero writes is legal: the stream outputs RES_SIZE copies of z.

Test Plan:
- Full map: start; write addr k with data k+1 for k=0..168; pe_done; out_ready=1 → bytes 1..169 in order; out_last only on the 169th byte; done 1 cycle later; wr_cnt=169; full=1; err=0.
- Sparse map + zero-point: z=8'h80; write only addr 0 (8'h11) and addr 168 (8'h22); pe_done → out[0]=11, out[1..167]=80, out[168]=22; wr_cnt=2; full=0.
- Backpressure: full map; out_ready toggles 1,0,0,1,… → no byte dropped or duplicated; out_data stable while out_ready=0; 169 handshakes total.
- Overwrite / out-of-range: write addr 5 twice (0x0A, then 0x0B) and addr 200 (0xFF) → out[5]=0x0B, wr_cnt=1, err=1; no memory corruption.
- Simultaneous events: wr_en (addr 168, 0x33) in the same cycle as pe_done → out[168]=0x33. A start pulse during DRAIN is ignored and the stream completes.
- Reset mid-stream: assert rst after 50 bytes accepted → next cycle out_valid=0, busy=0, wr_cnt=0. A new start, full map and pe_done streams from index 0.

Source files
------------

// File: rtl/pe_res_collector_if.sv
// PE result-write bus plus the outgoing raster stream of one collector.
// Stream handshake: a byte transfers on every rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready low, out_data and out_last hold stable.
interface pe_res_collector_if;
    logic       wr_en;
    logic [7:0] wr_adr;
    logic [7:0] wr_data;
    logic       pe_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output wr_en, wr_adr, wr_data, pe_done, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  wr_en, wr_adr, wr_data, pe_done, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/pe_res_collector.sv
// Captures one PE's convolution output map and replays it in raster order,
// substituting the zero-point for entries the PE never wrote.
module pe_res_collector #(
    parameter int IMG_SIZE    = 16,
    parameter int FILTER_SIZE = 4,
    parameter int RES_SIZE    = (IMG_SIZE - FILTER_SIZE + 1) * (IMG_SIZE - FILTER_SIZE + 1),
    parameter int CNT_W       = $clog2(RES_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       z,
    pe_res_collector_if.slave bus,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             full,
    output logic             err,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        FIN     = 2'd3
    } state_t;

    localparam logic [8:0] RES_LIM  = 9'(RES_SIZE);
    localparam logic [7:0] LAST_PTR = 8'(RES_SIZE - 1);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          rd_ptr;
    logic [RES_SIZE-1:0] wb;
    logic [7:0]          mem [RES_SIZE];

    logic in_range;
    logic wr_ok;
    logic wr_bad;
    logic at_last;
    logic hs;

    assign in_range = ({1'b0, bus.wr_adr} < RES_LIM);
    assign wr_ok    = (state == COLLECT) && bus.wr_en && in_range;
    assign wr_bad   = (state == COLLECT) && bus.wr_en && !in_range;
    assign at_last  = (rd_ptr == LAST_PTR);
    assign hs       = bus.out_valid && bus.out_ready;
    assign full     = (wr_cnt == CNT_W'(RES_SIZE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)          state_nxt = COLLECT;
            COLLECT: if (bus.pe_done)    state_nxt = DRAIN;
            DRAIN:   if (hs && at_last)  state_nxt = FIN;
            FIN:                         state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = 8'h00;
        busy          = (state != IDLE);
        done          = (state == FIN);
        dbg_state     = state;
        if (state == DRAIN) begin
            bus.out_valid = 1'b1;
            bus.out_last  = at_last;
            bus.out_data  = wb[rd_ptr] ? mem[rd_ptr] : z;
        end
    end

    // Bookkeeping: only the first write to an address counts toward wr_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 8'd0;
            wb     <= '0;
            wr_cnt <= '0;
            err    <= 1'b0;
        end else if ((state == IDLE) && start) begin
            rd_ptr <= 8'd0;
            wb     <= '0;
            wr_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_ok && !wb[bus.wr_adr]) begin
                wb[bus.wr_adr] <= 1'b1;
                wr_cnt         <= wr_cnt + CNT_W'(1);
            end
            if (wr_bad) begin
                err <= 1'b1;
            end
            if (hs && !at_last) begin
                rd_ptr <= rd_ptr + 8'd1;
            end
        end
    end

    // Data array has no reset; unwritten entries are masked by wb on readout.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_adr] <= bus.wr_data;
        end
    end

endmodule

// File: tb/tb_pe_res_collector.sv
// Directed bench for pe_res_collector: expected bytes are queued when a map is closed
// and a negedge monitor pops and compares every accepted stream byte.
module tb_pe_res_collector;

    localparam int RES = 169;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] z = 8'h00;
    logic [7:0] wr_cnt;
    logic       full;
    logic       err;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    pe_res_collector_if bus();

    pe_res_collector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .z         (z),
        .bus       (bus),
        .wr_cnt    (wr_cnt),
        .full      (full),
        .err       (err),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] exp_map[RES];
    int         hs_cnt = 0;
    int         done_seen = 0;
    bit         done_pending = 0;
    bit         hold = 0;
    logic [8:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (done_pending || done) begin
            check("done_pulse", {31'd0, done}, {31'd0, done_pending});
            done_pending = 0;
        end
        if (hold && bus.out_valid) begin
            check("hold_stable", {23'd0, bus.out_last, bus.out_data}, {23'd0, held});
        end
        hold = 0;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_byte: got %0h expected none", {bus.out_last, bus.out_data});
            end else begin
                e = exp_q.pop_front();
                check("stream_byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
            end
            hs_cnt++;
            if (bus.out_last) done_pending = 1;
        end else if (bus.out_valid) begin
            hold = 1;
            held = {bus.out_last, bus.out_data};
        end
        if (done) done_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_adr    = 8'h00;
        bus.wr_data   = 8'h00;
        bus.pe_done   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic write(input logic [7:0] adr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_adr  = adr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic fill_full();
        for (int k = 0; k < RES; k++) begin
            write(8'(k), 8'(k + 1));
            exp_map[k] = 8'(k + 1);
        end
    endtask

    task automatic set_map(input logic [7:0] v);
        for (int k = 0; k < RES; k++) exp_map[k] = v;
    endtask

    // Closes the map (optionally with a same-cycle write) and queues the expected stream.
    task automatic finish_map(input bit extra, input logic [7:0] adr, input logic [7:0] data);
        bus.pe_done = 1'b1;
        bus.wr_en   = extra;
        bus.wr_adr  = adr;
        bus.wr_data = data;
        tick();
        bus.pe_done = 1'b0;
        bus.wr_en   = 1'b0;
        for (int k = 0; k < RES; k++) exp_q.push_back({(k == RES - 1), exp_map[k]});
        @(negedge clk);
        check("first_valid_latency", {31'd0, bus.out_valid}, 32'd1);
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,...
    // start_at >= 0 pulses start plus an out-of-range write once that many bytes are accepted.
    // stop_at >= 0 stops accepting after that many bytes.
    task automatic drain(input int mode, input int start_at, input int stop_at);
        int snap;
        int c;
        bit fired;
        snap   = done_seen;
        c      = 0;
        fired  = 0;
        hs_cnt = 0;
        while (done_seen == snap && c < 3000) begin
            if (stop_at >= 0 && hs_cnt >= stop_at) break;
            bus.out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            if (start_at >= 0 && !fired && hs_cnt >= start_at) begin
                fired       = 1;
                start       = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_adr  = 8'd250;
                bus.wr_data = 8'h55;
            end
            tick();
            start     = 1'b0;
            bus.wr_en = 1'b0;
            c++;
        end
        bus.out_ready = 1'b0;
        if (stop_at < 0 && done_seen == snap) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d bytes expected done", hs_cnt);
        end
    endtask

    task automatic check_status(input string tag, input int cnt, input bit f, input bit e);
        @(negedge clk);
        check({tag, "_wr_cnt"}, {24'd0, wr_cnt}, cnt);
        check({tag, "_full"}, {31'd0, full}, {31'd0, f});
        check({tag, "_err"}, {31'd0, err}, {31'd0, e});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        // full map, ready always high
        tick();
        z = 8'h00;
        pulse_start();
        fill_full();
        finish_map(0, 8'h00, 8'h00);
        drain(0, -1, -1);
        check("full_hs_count", hs_cnt, RES);
        check_status("full", RES, 1, 0);

        // sparse map with zero-point substitution
        tick();
        z = 8'h80;
        pulse_start();
        set_map(8'h80);
        write(8'd0, 8'h11);
        write(8'd168, 8'h22);
        exp_map[0]   = 8'h11;
        exp_map[168] = 8'h22;
        finish_map(0, 8'h00, 8'h00);
        drain(0, -1, -1);
        check_status("sparse", 2, 0, 0);

        // backpressure
        tick();
        z = 8'h00;
        pulse_start();
        fill_full();
        finish_map(0, 8'h00, 8'h00);
        drain(1, -1, -1);
        check("bp_hs_count", hs_cnt, RES);
        check_status("bp", RES, 1, 0);

        // overwrite and out-of-range write
        tick();
        z = 8'h07;
        pulse_start();
        set_map(8'h07);
        write(8'd5, 8'h0A);
        write(8'd5, 8'h0B);
        write(8'd200, 8'hFF);
        exp_map[5] = 8'h0B;
        finish_map(0, 8'h00, 8'h00);
        drain(0, -1, -1);
        check_status("ovw", 1, 0, 1);

        // write coincident with pe_done; start and a bad write during DRAIN are ignored
        tick();
        z = 8'h00;
        pulse_start();
        set_map(8'h00);
        write(8'd0, 8'h44);
        exp_map[0]   = 8'h44;
        exp_map[168] = 8'h33;
        finish_map(1, 8'd168, 8'h33);
        drain(0, 20, -1);
        check("simul_hs_count", hs_cnt, RES);
        check_status("simul", 2, 0, 0);

        // reset mid-stream, then a clean full run
        tick();
        pulse_start();
        fill_full();
        finish_map(0, 8'h00, 8'h00);
        drain(0, -1, 50);
        check("mid_hs_count", hs_cnt, 50);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
        check("midrst_out_data", {24'd0, bus.out_data}, 32'd0);
        tick();
        pulse_start();
        fill_full();
        finish_map(0, 8'h00, 8'h00);
        drain(0, -1, -1);
        check("rerun_hs_count", hs_cnt, RES);
        check_status("rerun", RES, 1, 0);

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
